// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART TX frame sequencer (start, data, parity, stop).
// Optional second stop bit with `define UART_TX_STOP2_EN.
module uart_tx_ctrl #(
  parameter int IN_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
`ifdef UART_TX_STOP2_EN
  input  logic       STOP2,
`endif
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       BUSY,
  output logic       frame_done
);

  localparam int CNT_W =
    (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(IN_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
`ifdef UART_TX_STOP2_EN
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
`else
    S_STOP   = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_en_q, par_en_d;
  logic [1:0]       mux_sel_q, mux_sel_d;
  logic             busy_q, busy_d;
  logic             ser_en_q, ser_en_d;
  logic             done_q, done_d;
`ifdef UART_TX_STOP2_EN
  logic             stop2_q, stop2_d;
`endif

  // Load strobe is combinational so it matches DATA_VALID && !BUSY
  assign ser_load = DATA_VALID & (state_q == S_IDLE);

  // Next-state, bit counter and per-frame option latching
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = '0;
    par_en_d  = par_en_q;
`ifdef UART_TX_STOP2_EN
    stop2_d   = stop2_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          state_d  = S_START;
          par_en_d = PAR_EN;
`ifdef UART_TX_STOP2_EN
          stop2_d  = STOP2;
`endif
        end
      end
      S_START: state_d = S_DATA;
      S_DATA: begin
        if (bit_cnt_q == CNT_LAST) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: state_d = S_STOP;
`ifdef UART_TX_STOP2_EN
      S_STOP:  state_d = stop2_q ? S_STOP2 : S_IDLE;
      S_STOP2: state_d = S_IDLE;
`else
      S_STOP:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the next state, registered for glitch-free mux
  always_comb begin
    mux_sel_d = 2'b01;
    busy_d    = 1'b1;
    ser_en_d  = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      S_IDLE:   busy_d = 1'b0;
      S_START:  mux_sel_d = 2'b00;
      S_DATA: begin
        mux_sel_d = 2'b10;
        ser_en_d  = 1'b1;
      end
      S_PARITY: mux_sel_d = 2'b11;
`ifdef UART_TX_STOP2_EN
      S_STOP:   done_d = ~stop2_d;
      S_STOP2:  done_d = 1'b1;
`else
      S_STOP:   done_d = 1'b1;
`endif
      default:  busy_d = 1'b0;
    endcase
  end

  // FSM state, counter and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      mux_sel_q <= 2'b01;
      busy_q    <= 1'b0;
      ser_en_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      mux_sel_q <= mux_sel_d;
      busy_q    <= busy_d;
      ser_en_q  <= ser_en_d;
      done_q    <= done_d;
`ifdef UART_TX_STOP2_EN
      stop2_q   <= stop2_d;
`endif
    end
  end

  assign mux_sel    = mux_sel_q;
  assign BUSY       = busy_q;
  assign ser_en     = ser_en_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for the UART TX frame sequencer.
// Define UART_TX_STOP2_EN to also exercise the two-stop-bit frame.
module tb_uart_tx_ctrl;

  localparam int N = 8;

  logic       CLK;
  logic       RST;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       ser_load;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       BUSY;
  logic       frame_done;
`ifdef UART_TX_STOP2_EN
  logic       STOP2;
`endif

  int total;
  int bad;

  uart_tx_ctrl #(.IN_WIDTH(N)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
`ifdef UART_TX_STOP2_EN
    .STOP2      (STOP2),
`endif
    .ser_load   (ser_load),
    .ser_en     (ser_en),
    .mux_sel    (mux_sel),
    .BUSY       (BUSY),
    .frame_done (frame_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got,
                     input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_mux(input int i, input int p,
                                 input int s);
    if (i == 0) return 0;
    if (i <= N) return 2;
    if (p != 0 && i == N + 1) return 3;
    return 1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".mux"}, int'(mux_sel), 1);
    chk({tag, ".busy"}, int'(BUSY), 0);
    chk({tag, ".ser_en"}, int'(ser_en), 0);
    chk({tag, ".done"}, int'(frame_done), 0);
  endtask

  // Caller is just past a negedge with the DUT in IDLE.
  // abort >= 0 asserts reset at that frame cycle and returns.
  task automatic frame(input string tag, input int p, input int s,
                       input bit hold, input bit toggle,
                       input int abort);
    int len;
    int exp_len;
    int em;
    exp_len = 2 + N + p + s;
    len = 0;
    DATA_VALID = 1'b1;
    PAR_EN = p[0];
`ifdef UART_TX_STOP2_EN
    STOP2 = s[0];
`endif
    #1;
    chk({tag, ".load"}, int'(ser_load), 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (i == 0 && !hold) DATA_VALID = 1'b0;
      if (i == 3 && toggle) PAR_EN = ~PAR_EN;
      if (i == abort) begin
        RST = 1'b0;
        #1;
        chk_idle({tag, ".rst"});
        chk({tag, ".rst.load"}, int'(ser_load), 0);
        return;
      end
      #1;
      if (!BUSY) break;
      em = exp_mux(i, p, s);
      chk({tag, ".mux"}, int'(mux_sel), em);
      chk({tag, ".ser_en"}, int'(ser_en), (em == 2) ? 1 : 0);
      chk({tag, ".done"}, int'(frame_done),
          (i == exp_len - 1) ? 1 : 0);
      chk({tag, ".noload"}, int'(ser_load), 0);
      len++;
    end
    chk({tag, ".len"}, len, exp_len);
    chk_idle({tag, ".end"});
  endtask

  initial begin
    total = 0;
    bad = 0;
    DATA_VALID = 1'b0;
    PAR_EN = 1'b0;
`ifdef UART_TX_STOP2_EN
    STOP2 = 1'b0;
`endif
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    chk_idle("rst");
    chk("rst.load", int'(ser_load), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      chk_idle("idle");
      chk("idle.load", int'(ser_load), 0);
    end

    frame("par1", 1, 0, 1'b0, 1'b0, -1);
    @(negedge CLK);
    #1;
    frame("par0tog", 0, 0, 1'b0, 1'b1, -1);
    @(negedge CLK);
    #1;
    frame("par1tog", 1, 0, 1'b0, 1'b1, -1);

    @(negedge CLK);
    #1;
    frame("hold1", 1, 0, 1'b1, 1'b0, -1);
    frame("hold2", 0, 0, 1'b1, 1'b0, -1);
    frame("hold3", 1, 0, 1'b0, 1'b0, -1);

    @(negedge CLK);
    #1;
    frame("abort", 1, 0, 1'b0, 1'b0, 5);
    @(negedge CLK);
    #1;
    chk_idle("inrst");
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk_idle("postrst");
    frame("after", 1, 0, 1'b0, 1'b0, -1);

`ifdef UART_TX_STOP2_EN
    @(negedge CLK);
    #1;
    frame("stop2", 1, 1, 1'b0, 1'b0, -1);
    @(negedge CLK);
    #1;
    frame("stop2np", 0, 1, 1'b0, 1'b0, -1);
    @(negedge CLK);
    #1;
    frame("stop1", 1, 0, 1'b0, 1'b0, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
